myo_spi_scheduler: RTL

Sequences SPI motor-board transactions on one shared MYO SPI bus. It picks which motor is addressed, issues the per-motor start pulse to the SPI frame controller, and detects completion. After each completed frame it triggers the PID update for that motor and paces full sweeps to a programmable period. It sits between the Avalon register file (enable, mask, period) and the SPI frame controller and PID controller bank.

---
 rtl/myo_spi_scheduler_pkg.sv | 15 +
 rtl/myo_spi_scheduler_if.sv | 14 +
 rtl/myo_spi_scheduler_next_motor.sv | 24 ++
 rtl/myo_spi_scheduler.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/myo_spi_scheduler_pkg.sv
// Shared types for the MYO SPI scheduler: FSM states, index/counter widths,
// and a saturating increment for the sweep counter.
package myo_sched_pkg;
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, HOLD} sched_state_e;

    localparam int MOTOR_IDX_W = 8;
    localparam int SWEEP_CNT_W = 32;

    typedef logic [MOTOR_IDX_W-1:0] motor_idx_t;
    typedef logic [SWEEP_CNT_W-1:0] sweep_cnt_t;

    function automatic sweep_cnt_t sat_inc(sweep_cnt_t v);
        return (v == '1) ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/myo_spi_scheduler_if.sv
// Scheduler <-> SPI frame controller / PID bank handshake.
// master = scheduler side, slave = frame controller + PID bank side.
interface myo_spi_scheduler_if;
    import myo_sched_pkg::*;

    logic       start;
    motor_idx_t motor;
    logic       spi_done;
    logic       update_controller;
    motor_idx_t pid_update;

    modport master (output start, motor, update_controller, pid_update, input spi_done);
    modport slave  (input start, motor, update_controller, pid_update, output spi_done);
endinterface

// File: rtl/myo_spi_scheduler_next_motor.sv
// myo_next_motor: combinational search for the next set mask bit strictly above
// after_i; after_i = -1 returns the lowest set bit.
module myo_next_motor
    import myo_sched_pkg::*;
#(
    parameter int NUMBER_OF_MOTORS = 6
) (
    input  logic [NUMBER_OF_MOTORS-1:0] mask_i,
    input  logic signed [MOTOR_IDX_W:0] after_i,
    output motor_idx_t                  next_o,
    output logic                        found_o
);
    always_comb begin
        next_o  = '0;
        found_o = 1'b0;
        // Downward scan: the lowest qualifying bit is the last one written.
        for (int j = NUMBER_OF_MOTORS - 1; j >= 0; j--) begin
            if (mask_i[j] && (j > int'(after_i))) begin
                next_o  = motor_idx_t'(j);
                found_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/myo_spi_scheduler.sv
// myo_spi_scheduler: walks the motor mask on the shared MYO SPI bus, fires PID updates
// on frame completion and paces sweeps. Define MYO_SCHED_WATCHDOG_EN for the frame watchdog.
module myo_spi_scheduler
    import myo_sched_pkg::*;
#(
    parameter int NUMBER_OF_MOTORS = 6,
    parameter int TIMEOUT_CYCLES   = 5000
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic [NUMBER_OF_MOTORS-1:0] motor_mask,
    input  logic [31:0]                 period_cycles,
    myo_spi_scheduler_if.master         bus,
    output logic                        busy,
    output logic [31:0]                 sweep_cycles,
    output logic [15:0]                 timeout_count
);
    if (NUMBER_OF_MOTORS < 1 || NUMBER_OF_MOTORS > 254 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("myo_spi_scheduler: parameter out of range");
    end

    sched_state_e state_q, state_d;
    motor_idx_t   motor_q, motor_d, pid_q, pid_d;
    motor_idx_t   first_idx, next_idx;
    logic         first_found, next_found;
    logic         start_q, start_d, upd_q, upd_d, busy_q, busy_d, spi_done_q;
    sweep_cnt_t   cnt_q, cnt_d, sweep_q, sweep_d;
    logic         done_edge, period_hit, frame_end, expire, wrap;
    logic signed [MOTOR_IDX_W:0] after_cur;

    localparam logic signed [MOTOR_IDX_W:0] BEFORE_FIRST = '1;

    assign after_cur = {1'b0, motor_q};

    myo_next_motor #(.NUMBER_OF_MOTORS(NUMBER_OF_MOTORS)) u_first (
        .mask_i(motor_mask), .after_i(BEFORE_FIRST), .next_o(first_idx), .found_o(first_found)
    );

    myo_next_motor #(.NUMBER_OF_MOTORS(NUMBER_OF_MOTORS)) u_next (
        .mask_i(motor_mask), .after_i(after_cur), .next_o(next_idx), .found_o(next_found)
    );

    assign done_edge  = bus.spi_done & ~spi_done_q;
    assign period_hit = (period_cycles == '0) || (cnt_q >= period_cycles - 32'd1);
    assign frame_end  = (state_q == WAIT_DONE) && (done_edge || expire);
    // Last motor of a sweep wraps straight to LAUNCH when the period is already met,
    // so a free-running sweep costs no HOLD cycle.
    assign wrap = enable && first_found && period_hit &&
                  ((state_q == HOLD) || (frame_end && !next_found));

`ifdef MYO_SCHED_WATCHDOG_EN
    logic [31:0] wd_q, wd_d;
    logic [15:0] tmo_q, tmo_d;

    // Expiry behaves like a frame whose done edge lands TIMEOUT_CYCLES after start.
    assign expire = (state_q == WAIT_DONE) && !done_edge && (wd_q >= 32'(TIMEOUT_CYCLES));

    always_comb begin
        wd_d  = wd_q;
        tmo_d = tmo_q;
        if (state_q == LAUNCH)         wd_d = '0;
        else if (state_q == WAIT_DONE) wd_d = wd_q + 32'd1;
        if (expire && (tmo_q != '1))   tmo_d = tmo_q + 16'd1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wd_q  <= '0;
            tmo_q <= '0;
        end else begin
            wd_q  <= wd_d;
            tmo_q <= tmo_d;
        end
    end

    assign timeout_count = tmo_q;
`else
    assign expire        = 1'b0;
    assign timeout_count = '0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (enable && first_found) state_d = LAUNCH;
            end
            LAUNCH: begin
                state_d = enable ? WAIT_DONE : IDLE;
            end
            WAIT_DONE: begin
                if (frame_end) begin
                    if (!enable || !first_found)     state_d = IDLE;
                    else if (next_found || period_hit) state_d = LAUNCH;
                    else                             state_d = HOLD;
                end
            end
            HOLD: begin
                if (!enable)         state_d = IDLE;
                else if (period_hit) state_d = first_found ? LAUNCH : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        motor_d = motor_q;
        pid_d   = pid_q;
        upd_d   = 1'b0;
        sweep_d = sweep_q;
        cnt_d   = (state_q == IDLE) ? '0 : sat_inc(cnt_q);
        if ((state_q == WAIT_DONE) && done_edge) begin
            upd_d = 1'b1;
            pid_d = motor_q;
        end
        if ((state_d == LAUNCH) && (state_q != LAUNCH))
            motor_d = ((state_q == WAIT_DONE) && next_found) ? next_idx : first_idx;
        if (wrap) begin
            sweep_d = sat_inc(cnt_q);
            cnt_d   = '0;
        end
        start_d = (state_q == LAUNCH);
        busy_d  = (state_q != IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            motor_q    <= '0;
            pid_q      <= '0;
            upd_q      <= 1'b0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            cnt_q      <= '0;
            sweep_q    <= '0;
            spi_done_q <= 1'b0;
        end else begin
            motor_q    <= motor_d;
            pid_q      <= pid_d;
            upd_q      <= upd_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
            cnt_q      <= cnt_d;
            sweep_q    <= sweep_d;
            spi_done_q <= bus.spi_done;
        end
    end

    assign bus.start             = start_q;
    assign bus.motor             = motor_q;
    assign bus.update_controller = upd_q;
    assign bus.pid_update        = pid_q;
    assign busy                  = busy_q;
    assign sweep_cycles          = sweep_q;
endmodule
